writeback_arbiter: RTL and testbench

- Merges register writes from two sources into the single write port of the register file: the in-order pipeline writeback and the multi-cycle unit (mul/div) result.
- Multi-cycle results are queued in a small in-order FIFO and drained when the pipeline slot is free.
- Provides pending-destination query outputs to the hazard unit.
- Output write port is registered and drives the register file's write_enable/write_index/write_data directly.

---
 rtl/writeback_if.sv | 59 +++++
 rtl/writeback_arbiter.sv | 151 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Bundles the writeback arbiter's pipeline, multi-cycle, register-file and hazard-query signals.
// Optional forwarding signals appear only when WRITEBACK_FORWARD_EN is defined.
// master = sources/consumers around the arbiter, slave = the arbiter itself.
interface writeback_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
);
    logic             pipe_valid;
    logic [DEPTH-1:0] pipe_index;
    logic [WIDTH-1:0] pipe_data;
    logic             pipe_stall;

    logic             mc_valid;
    logic             mc_ready;
    logic [DEPTH-1:0] mc_index;
    logic [WIDTH-1:0] mc_data;

    logic             rf_write_enable;
    logic [DEPTH-1:0] rf_write_index;
    logic [WIDTH-1:0] rf_write_data;

    logic [DEPTH-1:0] query_index_1;
    logic [DEPTH-1:0] query_index_2;
    logic             query_hit_1;
    logic             query_hit_2;

`ifdef WRITEBACK_FORWARD_EN
    logic             fwd_valid_1;
    logic             fwd_valid_2;
    logic [WIDTH-1:0] fwd_data_1;
    logic [WIDTH-1:0] fwd_data_2;
`endif

    modport master (
        output pipe_valid, pipe_index, pipe_data,
        input  pipe_stall,
        output mc_valid, mc_index, mc_data,
        input  mc_ready,
        input  rf_write_enable, rf_write_index, rf_write_data,
        output query_index_1, query_index_2,
`ifdef WRITEBACK_FORWARD_EN
        input  fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
`endif
        input  query_hit_1, query_hit_2
    );

    modport slave (
        input  pipe_valid, pipe_index, pipe_data,
        output pipe_stall,
        input  mc_valid, mc_index, mc_data,
        output mc_ready,
        output rf_write_enable, rf_write_index, rf_write_data,
        input  query_index_1, query_index_2,
`ifdef WRITEBACK_FORWARD_EN
        output fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
`endif
        output query_hit_1, query_hit_2
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Purpose: merge pipeline writeback and queued multi-cycle results into one register-file write port.
// Latency: pipeline 1 cycle; multi-cycle >= 2 cycles (push, then pop); no fall-through.
// Backpressure: mc_ready low when queue full; pipe_stall high when full so the queue drains first.
// Optional feature macro: WRITEBACK_FORWARD_EN (adds fwd_valid_n/fwd_data_n outputs).
module writeback_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    writeback_if.slave   wb
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // queue storage and control
    logic [DEPTH-1:0] q_idx [FIFO_DEPTH];
    logic [WIDTH-1:0] q_dat [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // registered outputs
    logic             mc_ready_q;
    logic             pipe_stall_q;
    logic             we_q;
    logic [DEPTH-1:0] idx_q;
    logic [WIDTH-1:0] dat_q;

    logic push;
    logic pop;
    logic take_pipe;
    logic fifo_ne;
    logic pipe_req;

    // Index 0 completes the handshake but is never stored.
    assign push     = wb.mc_valid && mc_ready_q && (wb.mc_index != '0);
    assign fifo_ne  = (count != '0);
    assign pipe_req = wb.pipe_valid && (wb.pipe_index != '0);

    // Slot selection: a full queue (pipe stalled) drains first, otherwise the pipeline wins.
    always_comb begin
        pop       = 1'b0;
        take_pipe = 1'b0;
        if (pipe_stall_q && fifo_ne) begin
            pop = 1'b1;
        end else if (pipe_req) begin
            take_pipe = 1'b1;
        end else if (fifo_ne) begin
            pop = 1'b1;
        end
    end

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Queue payload; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= wb.mc_index;
            q_dat[wr_ptr] <= wb.mc_data;
        end
    end

    // Pointers, occupancy, handshake flags and the register-file write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mc_ready_q   <= 1'b0;
            pipe_stall_q <= 1'b0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            dat_q        <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count        <= count_next;
            mc_ready_q   <= (count_next < CNT_W'(FIFO_DEPTH));
            pipe_stall_q <= (count_next == CNT_W'(FIFO_DEPTH));
            if (take_pipe) begin
                we_q  <= 1'b1;
                idx_q <= wb.pipe_index;
                dat_q <= wb.pipe_data;
            end else if (pop) begin
                we_q  <= 1'b1;
                idx_q <= q_idx[rd_ptr];
                dat_q <= q_dat[rd_ptr];
            end else begin
                we_q  <= 1'b0;
            end
        end
    end

    assign wb.mc_ready        = mc_ready_q;
    assign wb.pipe_stall      = pipe_stall_q;
    assign wb.rf_write_enable = we_q;
    assign wb.rf_write_index  = idx_q;
    assign wb.rf_write_data   = dat_q;

    logic [DEPTH-1:0] qry     [2];
    logic             fifo_hit[2];
    logic             out_hit [2];
    logic             hit     [2];
`ifdef WRITEBACK_FORWARD_EN
    logic [WIDTH-1:0] fifo_fwd[2];
    logic             fwd_v   [2];
    logic [WIDTH-1:0] fwd_d   [2];
`endif

    assign qry[0] = wb.query_index_1;
    assign qry[1] = wb.query_index_2;

    // Hazard query: scan live queue entries head to tail so the newest match ends up last.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            fifo_hit[q] = 1'b0;
            out_hit[q]  = we_q && (idx_q == qry[q]);
`ifdef WRITEBACK_FORWARD_EN
            fifo_fwd[q] = '0;
`endif
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if ((CNT_W'(k) < count) && (q_idx[rd_ptr + PTR_W'(k)] == qry[q])) begin
                    fifo_hit[q] = 1'b1;
`ifdef WRITEBACK_FORWARD_EN
                    fifo_fwd[q] = q_dat[rd_ptr + PTR_W'(k)];
`endif
                end
            end
`ifdef WRITEBACK_FORWARD_EN
            // The output register is forwarded instead of stalled on; it is the newest value.
            hit[q]   = (qry[q] != '0) && fifo_hit[q];
            fwd_v[q] = (qry[q] != '0) && (out_hit[q] || fifo_hit[q]);
            fwd_d[q] = out_hit[q] ? dat_q : fifo_fwd[q];
`else
            hit[q]   = (qry[q] != '0) && (fifo_hit[q] || out_hit[q]);
`endif
        end
    end

    assign wb.query_hit_1 = hit[0];
    assign wb.query_hit_2 = hit[1];
`ifdef WRITEBACK_FORWARD_EN
    assign wb.fwd_valid_1 = fwd_v[0];
    assign wb.fwd_valid_2 = fwd_v[1];
    assign wb.fwd_data_1  = fwd_d[0];
    assign wb.fwd_data_2  = fwd_d[1];
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Honours WRITEBACK_FORWARD_EN for the query/forward expectations.
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    writeback_if #(.WIDTH(32), .DEPTH(5)) wb ();

    writeback_arbiter #(.WIDTH(32), .DEPTH(5), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] idx, input logic [31:0] dat);
        check({tag, ".we"},  64'(wb.rf_write_enable), 64'(we));
        check({tag, ".idx"}, 64'(wb.rf_write_index),  64'(idx));
        check({tag, ".dat"}, 64'(wb.rf_write_data),   64'(dat));
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] idx, input logic [31:0] dat);
        wb.pipe_valid = v;
        wb.pipe_index = idx;
        wb.pipe_data  = dat;
    endtask

    task automatic set_mc(input logic v, input logic [4:0] idx, input logic [31:0] dat);
        wb.mc_valid = v;
        wb.mc_index = idx;
        wb.mc_data  = dat;
    endtask

    initial begin
        reset = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        wb.query_index_1 = 5'd0;
        wb.query_index_2 = 5'd0;

        // reset held two cycles
        tick();
        tick();
        chk_rf("rst", 1'b0, 5'd0, 32'h0);
        check("rst.ready", 64'(wb.mc_ready),   64'd0);
        check("rst.stall", 64'(wb.pipe_stall), 64'd0);

        // pipeline write, 1-cycle latency
        reset = 1'b1;
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk_rf("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
        check("pipe5.ready", 64'(wb.mc_ready), 64'd1);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // single multi-cycle push, written two edges after handshake
        set_mc(1'b1, 5'd7, 32'h12);
        wb.query_index_1 = 5'd7;
        tick();
        check("mc7.we0", 64'(wb.rf_write_enable), 64'd0);
        check("mc7.hitq", 64'(wb.query_hit_1), 64'd1);
        set_mc(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("mc7", 1'b1, 5'd7, 32'h12);
`ifdef WRITEBACK_FORWARD_EN
        check("mc7.hito", 64'(wb.query_hit_1), 64'd0);
        check("mc7.fwdv", 64'(wb.fwd_valid_1), 64'd1);
        check("mc7.fwdd", 64'(wb.fwd_data_1),  64'h12);
`else
        check("mc7.hito", 64'(wb.query_hit_1), 64'd1);
`endif
        tick();
        check("mc7.done", 64'(wb.rf_write_enable), 64'd0);
        check("mc7.hit0", 64'(wb.query_hit_1), 64'd0);
        check("mc7.ready", 64'(wb.mc_ready), 64'd1);

        // fill the queue while the pipeline is busy
        set_pipe(1'b1, 5'd3, 32'h333);
        set_mc(1'b1, 5'd8, 32'h88);
        tick();
        chk_rf("fill1", 1'b1, 5'd3, 32'h333);
        check("fill1.ready", 64'(wb.mc_ready),   64'd1);
        check("fill1.stall", 64'(wb.pipe_stall), 64'd0);
        set_mc(1'b1, 5'd9, 32'h99);
        tick();
        chk_rf("fill2", 1'b1, 5'd3, 32'h333);
        check("fill2.ready", 64'(wb.mc_ready),   64'd0);
        check("fill2.stall", 64'(wb.pipe_stall), 64'd1);
        set_mc(1'b1, 5'd13, 32'hD);   // offered while not ready: must be dropped
        tick();
        chk_rf("drain8", 1'b1, 5'd8, 32'h88);
        check("drain8.ready", 64'(wb.mc_ready),   64'd1);
        check("drain8.stall", 64'(wb.pipe_stall), 64'd0);
        set_mc(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("pipe3", 1'b1, 5'd3, 32'h333);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("drain9", 1'b1, 5'd9, 32'h99);
        tick();
        check("no13.we", 64'(wb.rf_write_enable), 64'd0);

        // index 0 on both sources: nothing written, nothing pending
        set_mc(1'b1, 5'd0, 32'h55);
        set_pipe(1'b1, 5'd0, 32'hFF);
        wb.query_index_1 = 5'd0;
        tick();
        check("zero.we",    64'(wb.rf_write_enable), 64'd0);
        check("zero.ready", 64'(wb.mc_ready),        64'd1);
        check("zero.hit",   64'(wb.query_hit_1),     64'd0);
        set_mc(1'b0, 5'd0, 32'h0);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("zero.we2", 64'(wb.rf_write_enable), 64'd0);

        // queued index 10 behind a busy pipeline, with hazard queries
        set_pipe(1'b1, 5'd4, 32'h44);
        set_mc(1'b1, 5'd10, 32'hA0A0);
        wb.query_index_1 = 5'd10;
        wb.query_index_2 = 5'd4;
        tick();
        chk_rf("q10a", 1'b1, 5'd4, 32'h44);
        check("q10a.hit1", 64'(wb.query_hit_1), 64'd1);
`ifdef WRITEBACK_FORWARD_EN
        check("q10a.hit2", 64'(wb.query_hit_2), 64'd0);
        check("q10a.fwdv2", 64'(wb.fwd_valid_2), 64'd1);
        check("q10a.fwdd2", 64'(wb.fwd_data_2),  64'h44);
`else
        check("q10a.hit2", 64'(wb.query_hit_2), 64'd1);
`endif
        set_mc(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("q10b", 1'b1, 5'd4, 32'h44);
        check("q10b.hit1", 64'(wb.query_hit_1), 64'd1);
`ifdef WRITEBACK_FORWARD_EN
        check("q10b.fwdv1", 64'(wb.fwd_valid_1), 64'd1);
        check("q10b.fwdd1", 64'(wb.fwd_data_1),  64'hA0A0);
`endif
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("q10c", 1'b1, 5'd10, 32'hA0A0);
        check("q10c.hit2", 64'(wb.query_hit_2), 64'd0);
`ifdef WRITEBACK_FORWARD_EN
        check("q10c.hit1", 64'(wb.query_hit_1), 64'd0);
        check("q10c.fwdd1", 64'(wb.fwd_data_1), 64'hA0A0);
`else
        check("q10c.hit1", 64'(wb.query_hit_1), 64'd1);
`endif
        tick();
        check("q10d.we",   64'(wb.rf_write_enable), 64'd0);
        check("q10d.hit1", 64'(wb.query_hit_1),     64'd0);

        // reset with two entries queued discards them
        set_pipe(1'b1, 5'd3, 32'h333);
        set_mc(1'b1, 5'd11, 32'hB1);
        tick();
        set_mc(1'b1, 5'd12, 32'hC2);
        tick();
        check("pre_rst.stall", 64'(wb.pipe_stall), 64'd1);
        reset = 1'b0;
        set_mc(1'b0, 5'd0, 32'h0);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("mid_rst", 1'b0, 5'd0, 32'h0);
        check("mid_rst.ready", 64'(wb.mc_ready),   64'd0);
        check("mid_rst.stall", 64'(wb.pipe_stall), 64'd0);
        reset = 1'b1;
        wb.query_index_1 = 5'd11;
        wb.query_index_2 = 5'd12;
        tick();
        check("post_rst.we",    64'(wb.rf_write_enable), 64'd0);
        check("post_rst.ready", 64'(wb.mc_ready),        64'd1);
        check("post_rst.stall", 64'(wb.pipe_stall),      64'd0);
        check("post_rst.hit1",  64'(wb.query_hit_1),     64'd0);
        check("post_rst.hit2",  64'(wb.query_hit_2),     64'd0);
        tick();
        check("post_rst.we2",   64'(wb.rf_write_enable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
